// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// Peripheral-bus view of the interrupt controller register block.
//   rd    : read strobe, already qualified by the peripheral address decode
//   wr    : write strobe, already qualified by the peripheral address decode
//   addr  : byte address; the controller decodes only addr[7:0]
//   wdata : write data
//   rdata : combinational read data returned by the controller
// master = CPU / bus side, slave = the controller.
// -----------------------------------------------------------------------------
interface irq_controller_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd,
    output wr,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  rd,
    input  wr,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Memory-mapped interrupt controller. Latches rising edges of the source lines
// as pending bits, masks them with per-source enables and a global enable,
// picks the lowest-index (highest-priority) source when the CPU takes the
// interrupt, and blocks further requests until software writes EOI.
//
// Register map (byte offsets from BASE, word registers):
//   +0  IER    [NSRC-1:0] source enables, R/W
//   +4  IPR    [NSRC-1:0] pending, read / write-1-to-clear
//   +8  ICAUSE [31] valid, [2:0] source id; read-only, any write = EOI
//   +12 ICTRL  [0] GIE R/W, [1] in_service read-only
//
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset
//   bus       : register bus (rd/wr/addr/wdata in, rdata out)
//   src_irq   : source event lines, synchronous to clk, level or pulse
//   ker       : CPU is in kernel mode; suppresses the request
//   irq_taken : one-cycle pulse, CPU vectored to the interrupt handler
//   irqout    : interrupt request to the CPU control unit
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int         NSRC = 4,
  parameter logic [7:0] BASE = 8'h30
) (
  input  logic               clk,
  input  logic               reset,
  irq_controller_if.slave    bus,
  input  logic [NSRC-1:0]    src_irq,
  input  logic               ker,
  input  logic               irq_taken,
  output logic               irqout
);

  localparam logic [7:0] OFF_IER    = BASE;
  localparam logic [7:0] OFF_IPR    = BASE + 8'd4;
  localparam logic [7:0] OFF_ICAUSE = BASE + 8'd8;
  localparam logic [7:0] OFF_ICTRL  = BASE + 8'd12;

  // Architectural state
  logic [NSRC-1:0] ier;
  logic [NSRC-1:0] ipr;
  logic [NSRC-1:0] s_q;          // previous-cycle source levels for edge detect
  logic            gie;
  logic            in_service;
  logic            cause_valid;
  logic [2:0]      cause_id;

  // Decode of the low address byte only; the upper decode lives in the bus mux.
  logic [7:0] off;
  logic       hit_ier, hit_ipr, hit_icause, hit_ictrl;

  assign off        = bus.addr[7:0];
  assign hit_ier    = (off == OFF_IER);
  assign hit_ipr    = (off == OFF_IPR);
  assign hit_icause = (off == OFF_ICAUSE);
  assign hit_ictrl  = (off == OFF_ICTRL);

  logic ier_we, ictrl_we, eoi;
  logic [NSRC-1:0] w1c_mask;

  assign ier_we   = bus.wr & hit_ier;
  assign ictrl_we = bus.wr & hit_ictrl;
  assign eoi      = bus.wr & hit_icause;
  assign w1c_mask = (bus.wr & hit_ipr) ? bus.wdata[NSRC-1:0] : '0;

  // A line held high produces a single rise, so it sets pending only once.
  logic [NSRC-1:0] rise;
  assign rise = src_irq & ~s_q;

  // Priority select: lowest index among enabled pending sources.
  logic [NSRC-1:0] active;
  logic [2:0]      sel_id;
  logic            any_active;

  assign active = ipr & ier;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    sel_id     = '0;
    any_active = 1'b0;
    // Walk from the top so the lowest set index is the last one written.
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_id     = 3'(i);
        any_active = 1'b1;
      end
    end
  end

  logic            take;
  logic [NSRC-1:0] take_mask;
  logic [NSRC-1:0] ipr_next;

  assign take      = irq_taken & any_active;
  assign take_mask = take ? (NSRC'(1) << sel_id) : '0;
  // A rise in the same cycle beats both W1C and the take-clear.
  assign ipr_next  = rise | (ipr & ~w1c_mask & ~take_mask);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      ier         <= '0;
      ipr         <= '0;
      s_q         <= '0;
      gie         <= 1'b0;
      in_service  <= 1'b0;
      cause_valid <= 1'b0;
      cause_id    <= '0;
    end else begin
      s_q <= src_irq;
      ipr <= ipr_next;
      if (ier_we)   ier <= bus.wdata[NSRC-1:0];
      if (ictrl_we) gie <= bus.wdata[0];

      if (irq_taken) begin
        if (any_active) begin
          // Take beats a simultaneous EOI: the new interrupt is in service.
          cause_valid <= 1'b1;
          cause_id    <= sel_id;
          in_service  <= 1'b1;
        end else begin
          // Spurious take: nothing qualified, so no cause is recorded.
          cause_valid <= 1'b0;
          cause_id    <= '0;
          if (eoi) in_service <= 1'b0;
        end
      end else if (eoi) begin
        // EOI drops valid but keeps the last id visible to software.
        cause_valid <= 1'b0;
        in_service  <= 1'b0;
      end
    end
  end

  // No nesting: once in service, new pending bits wait for EOI.
  assign irqout = gie & ~in_service & ~ker & (|active);

  always_comb begin
    bus.rdata = '0;
    if (bus.rd) begin
      if (hit_ier)    bus.rdata = {{(32-NSRC){1'b0}}, ier};
      if (hit_ipr)    bus.rdata = {{(32-NSRC){1'b0}}, ipr};
      if (hit_icause) bus.rdata = {cause_valid, 28'b0, cause_id};
      if (hit_ictrl)  bus.rdata = {30'b0, in_service, gie};
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Drives directed scenarios and randomized traffic into irq_controller. A
// behavioural model, written as plain bitmask arithmetic over the register
// rules, produces the expected irqout and rdata for every cycle; those
// expectations are queued when the stimulus is applied and a monitor pops and
// compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_irq_controller;

  localparam int         NSRC = 4;
  localparam logic [7:0] BASE = 8'h30;
  localparam logic [7:0] O_IER = BASE, O_IPR = BASE + 8'd4,
                         O_ICAUSE = BASE + 8'd8, O_ICTRL = BASE + 8'd12;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic            ker;
  logic            irq_taken;
  logic            irqout;

  irq_controller_if bus_if ();

  irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .src_irq   (src_irq),
    .ker       (ker),
    .irq_taken (irq_taken),
    .irqout    (irqout)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit          is_rdata;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // ---------------------------------------------------------------- model
  int m_ier, m_ipr, m_prev, m_cid;
  bit m_gie, m_insvc, m_cvalid;

  logic [3:0] cur_src = '0;
  bit         cur_ker = 1'b0;

  function automatic void model_reset();
    m_ier = 0; m_ipr = 0; m_prev = 0; m_cid = 0;
    m_gie = 0; m_insvc = 0; m_cvalid = 0;
  endfunction

  function automatic int first_set(int v);
    for (int i = 0; i < NSRC; i++)
      if (v % (2 ** (i + 1)) >= 2 ** i) return i;
    return -1;
  endfunction

  function automatic bit model_irqout();
    return m_gie && !m_insvc && !cur_ker && ((m_ipr & m_ier) != 0);
  endfunction

  function automatic logic [31:0] model_rdata(bit rd_i, logic [31:0] a);
    if (!rd_i) return 32'h0;
    case (a[7:0])
      O_IER:    return 32'(m_ier);
      O_IPR:    return 32'(m_ipr);
      O_ICAUSE: return (m_cvalid ? 32'h8000_0000 : 32'h0) + 32'(m_cid);
      O_ICTRL:  return 32'(2 * int'(m_insvc) + int'(m_gie));
      default:  return 32'h0;
    endcase
  endfunction

  function automatic void model_update(bit rst_i, bit wr_i, logic [31:0] a,
                                       logic [31:0] wd, bit tk, int src);
    int rise, w1c, sel, cleared, n_ipr;
    bit eoi;
    if (rst_i) begin
      model_reset();
      return;
    end
    rise = src & ~m_prev & 15;
    w1c  = (wr_i && a[7:0] == O_IPR) ? int'(wd[3:0]) : 0;
    eoi  = wr_i && a[7:0] == O_ICAUSE;
    sel  = first_set(m_ipr & m_ier);
    cleared = (tk && sel >= 0) ? (1 << sel) : 0;
    n_ipr = 0;
    for (int i = 0; i < NSRC; i++) begin
      bit was, r, c;
      was = ((m_ipr >> i) & 1) == 1;
      r   = ((rise >> i) & 1) == 1;
      c   = (((w1c | cleared) >> i) & 1) == 1;
      if (r || (was && !c)) n_ipr += (1 << i);
    end
    if (tk) begin
      if (sel >= 0) begin
        m_cvalid = 1; m_cid = sel; m_insvc = 1;
      end else begin
        m_cvalid = 0; m_cid = 0;
        if (eoi) m_insvc = 0;
      end
    end else if (eoi) begin
      m_cvalid = 0; m_insvc = 0;
    end
    if (wr_i && a[7:0] == O_IER)   m_ier = int'(wd[3:0]);
    if (wr_i && a[7:0] == O_ICTRL) m_gie = wd[0];
    m_ipr  = n_ipr;
    m_prev = src;
  endfunction

  // ------------------------------------------------------------- stimulus
  task automatic step(input bit rst_i, input bit rd_i, input bit wr_i,
                      input logic [31:0] a, input logic [31:0] wd, input bit tk,
                      input bit use_const, input logic [31:0] cval,
                      input string nm);
    exp_t e;
    reset        = rst_i;
    bus_if.rd    = rd_i;
    bus_if.wr    = wr_i;
    bus_if.addr  = a;
    bus_if.wdata = wd;
    src_irq      = cur_src;
    ker          = cur_ker;
    irq_taken    = tk;
    e.is_rdata = 1'b0; e.val = {31'b0, model_irqout()}; e.name = "irqout";
    exp_q.push_back(e);
    e.is_rdata = 1'b1; e.val = use_const ? cval : model_rdata(rd_i, a); e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    model_update(rst_i, wr_i, a, wd, tk, int'(cur_src));
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h4000_0000, 0, 0, 0, 0, "idle");
  endtask

  task automatic wr_reg(input logic [7:0] o, input logic [31:0] v);
    step(0, 0, 1, {24'h400000, o}, v, 0, 0, 0, "wr");
  endtask

  task automatic rd_const(input logic [7:0] o, input logic [31:0] v, input string nm);
    step(0, 1, 0, {24'h400000, o}, 0, 0, 1, v, nm);
  endtask

  task automatic take();
    step(0, 0, 0, 32'h4000_0000, 0, 1, 0, 0, "take");
  endtask

  // -------------------------------------------------------------- monitor
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = exp_q.pop_front();
      act = e.is_rdata ? bus_if.rdata : {31'b0, irqout};
      tests++;
      if (act !== e.val) begin
        failed++;
        $display("FAIL %s at %0t: got %h expected %h", e.name, $time, act, e.val);
      end
    end
  end

  // ----------------------------------------------------------------- main
  initial begin
    reset = 1'b1; bus_if.rd = 0; bus_if.wr = 0; bus_if.addr = 0; bus_if.wdata = 0;
    src_irq = '0; ker = 0; irq_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state, basic request/take/EOI
    rd_const(O_IER, 0, "rst_ier");
    rd_const(O_IPR, 0, "rst_ipr");
    rd_const(O_ICAUSE, 0, "rst_icause");
    rd_const(O_ICTRL, 0, "rst_ictrl");
    step(0, 0, 0, {24'h400000, O_IER}, 0, 0, 1, 0, "no_rd_zero");
    wr_reg(O_IER, 32'h1);
    wr_reg(O_ICTRL, 32'h1);
    idle(3);
    cur_src = 4'b0001; idle(1);
    cur_src = 4'b0000; idle(1);            // irqout expected high here
    take();
    rd_const(O_ICAUSE, 32'h8000_0000, "t1_icause");
    rd_const(O_IPR, 0, "t1_ipr");
    wr_reg(O_ICAUSE, 0);
    rd_const(O_ICTRL, 32'h1, "t1_ictrl_eoi");

    // 2: priority between two simultaneous sources
    wr_reg(O_IER, 32'hF);
    cur_src = 4'b1010; idle(1);
    cur_src = 4'b0000;
    rd_const(O_IPR, 32'hA, "t2_ipr");
    take();
    rd_const(O_ICAUSE, 32'h8000_0001, "t2_first");
    wr_reg(O_ICAUSE, 0);
    idle(1);
    take();
    rd_const(O_ICAUSE, 32'h8000_0003, "t2_second");
    wr_reg(O_ICAUSE, 0);

    // 3: held level sets once; W1C while held does not re-set
    cur_src = 4'b0100;
    idle(50);
    rd_const(O_IPR, 32'h4, "t3_ipr_held");
    wr_reg(O_IPR, 32'h4);
    rd_const(O_IPR, 0, "t3_ipr_w1c");
    idle(5);
    rd_const(O_IPR, 0, "t3_ipr_stays");
    cur_src = 4'b0000;

    // 4: masking by IER, GIE and ker
    wr_reg(O_IER, 0);
    cur_src = 4'b0001; idle(1); cur_src = 4'b0000;
    rd_const(O_IPR, 32'h1, "t4_ipr");
    wr_reg(O_IER, 32'h1);
    wr_reg(O_ICTRL, 0);
    idle(2);
    wr_reg(O_ICTRL, 32'h1);
    idle(1);
    cur_ker = 1'b1; idle(2); cur_ker = 1'b0;
    idle(1);

    // 5: set beats clear
    cur_src = 4'b0010;
    wr_reg(O_IPR, 32'h2);
    cur_src = 4'b0000;
    rd_const(O_IPR, 32'h3, "t5_w1c_vs_rise");
    cur_src = 4'b0001;
    take();
    cur_src = 4'b0000;
    rd_const(O_IPR, 32'h3, "t5_take_vs_rise");
    rd_const(O_ICAUSE, 32'h8000_0000, "t5_icause");

    // 6: no nesting, then reset clears everything
    cur_src = 4'b0100; idle(1); cur_src = 4'b0000;
    idle(2);
    rd_const(O_IPR, 32'h7, "t6_ipr_accum");
    step(1, 0, 0, 32'h4000_0000, 0, 0, 0, 0, "reset");
    rd_const(O_IPR, 0, "t6_ipr");
    rd_const(O_IER, 0, "t6_ier");
    rd_const(O_ICAUSE, 0, "t6_icause");
    rd_const(O_ICTRL, 0, "t6_ictrl");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, wd;
      int pick;
      bit rst_r, rd_r, wr_r, tk_r;
      cur_src = cur_src ^ 4'($urandom & $urandom & $urandom);
      cur_ker = ($urandom_range(0, 9) == 0);
      pick    = $urandom_range(0, 4);
      a       = $urandom;
      a[7:0]  = (pick < 4) ? BASE + 8'(4 * pick) : 8'($urandom);
      wd      = $urandom;
      rst_r   = ($urandom_range(0, 199) == 0);
      rd_r    = $urandom_range(0, 1) == 1;
      wr_r    = ($urandom_range(0, 3) == 0);
      tk_r    = ($urandom_range(0, 5) == 0);
      step(rst_r, rd_r, wr_r, a, wd, tk_r, 0, 0, "rand_rdata");
    end

    idle(2);
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
